// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the multicycle CPU. Accepts the
//   two register-file operands on a start request and returns the
//   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU result with a one-cycle write
//   strobe for the register-file write port.
//
//   Datapath: operands are reduced to magnitudes at accept, the core loop
//   works unsigned (shift-add multiply or restoring divide, one bit per
//   cycle, XLEN cycles), and the sign is re-applied when the result is
//   registered.
//
//   Optional build macro:
//     MULDIV_FAST_MUL_EN - multiplies use a single-cycle full-width product
//                          registered at accept (IDLE -> DONE). Divides are
//                          unchanged. Undefined: all ops are iterative.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset, aborts any operation
//   start       request, sampled only while idle
//   funct3      RV32M operation select
//   operand_a   rs1 value
//   operand_b   rs2 value
//   dest_reg    rd index
//   busy        operation in flight (control unit stalls on this)
//   done        one-cycle result-valid pulse
//   result      computed value, held until the next completion
//   result_reg  rd index belonging to result
//   reg_write   done qualified by result_reg != 0
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] result_reg,
  output logic                  reg_write
);

  localparam int                AW       = 2 * XLEN;
  localparam int                CW       = $clog2(XLEN);
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [AW-1:0]     ZERO_W   = {AW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement negate when en is set
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    logic [XLEN-1:0] r;
    if (en) begin
      r = ZERO - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Double-width variant for the full product
  function automatic logic [AW-1:0] neg_wide_if(input logic [AW-1:0] v, input logic en);
    logic [AW-1:0] r;
    if (en) begin
      r = ZERO_W - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t                  state_r;
  logic [CW-1:0]           counter_r;
  logic [2:0]              op_r;
  logic [REG_ADDR_W-1:0]   rd_r;
  logic [XLEN-1:0]         ma_r;
  logic [XLEN-1:0]         mb_r;
  logic                    neg_r;
  // Multiply: {high partial, multiplier shifting out}. Divide: {remainder, quotient}.
  logic [AW-1:0]           acc_r;

  logic                    a_signed_s;
  logic                    b_signed_s;
  logic                    sa_s;
  logic                    sb_s;
  logic [XLEN-1:0]         ma_start_s;
  logic [XLEN-1:0]         mb_start_s;
  logic                    neg_start_s;
  logic                    div_zero_s;
  logic                    div_ovf_s;

  logic [XLEN:0]           mul_sum_s;
  logic [AW-1:0]           mul_next_s;
  logic [XLEN:0]           rem_shift_s;
  logic [XLEN-1:0]         div_diff_s;
  logic [AW-1:0]           div_next_s;

  logic [AW-1:0]           prod_fix_s;
  logic [XLEN-1:0]         lo_fix_s;
  logic [XLEN-1:0]         hi_fix_s;
  logic [XLEN-1:0]         final_s;

  // Request decode: operand signedness, magnitudes, result sign, special cases
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (funct3)
      3'b001:         begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b010:         begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      3'b100, 3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    sa_s       = a_signed_s & operand_a[XLEN-1];
    sb_s       = b_signed_s & operand_b[XLEN-1];
    ma_start_s = neg_if(operand_a, sa_s);
    mb_start_s = neg_if(operand_b, sb_s);
    // Remainder follows the dividend; product and quotient follow sa^sb
    if (funct3[2] && funct3[1]) begin
      neg_start_s = sa_s;
    end else begin
      neg_start_s = sa_s ^ sb_s;
    end
    div_zero_s = funct3[2] & (operand_b == ZERO);
    div_ovf_s  = funct3[2] & ~funct3[0] & (operand_a == INT_MIN) & (operand_b == ALL_ONES);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [AW-1:0] fast_a_s;
  logic [AW-1:0] fast_b_s;
  logic [AW-1:0] fast_prod_s;

  // Single-cycle product; sign extension makes the truncated product exact
  always_comb begin
    fast_a_s    = {{XLEN{sa_s}}, operand_a};
    fast_b_s    = {{XLEN{sb_s}}, operand_b};
    fast_prod_s = fast_a_s * fast_b_s;
  end
`endif

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[AW-1:XLEN]} + {1'b0, ma_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[AW-1:XLEN]};
    end
    mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};

    rem_shift_s = {acc_r[AW-1:XLEN], acc_r[XLEN-1]};
    // Only used when the trial subtract succeeds, so the top bit is always zero
    div_diff_s  = rem_shift_s[XLEN-1:0] - mb_r;
    if (rem_shift_s >= {1'b0, mb_r}) begin
      div_next_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
    end else begin
      div_next_s = {rem_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result field select
  always_comb begin
    prod_fix_s = neg_wide_if(acc_r, neg_r);
    lo_fix_s   = neg_if(acc_r[XLEN-1:0], neg_r);
    hi_fix_s   = neg_if(acc_r[AW-1:XLEN], neg_r);
    case (op_r)
      3'b000:                 final_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_s = prod_fix_s[AW-1:XLEN];
      3'b100, 3'b101:         final_s = lo_fix_s;
      3'b110, 3'b111:         final_s = hi_fix_s;
      default:                final_s = ZERO;
    endcase
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      counter_r  <= {CW{1'b0}};
      op_r       <= 3'b000;
      rd_r       <= {REG_ADDR_W{1'b0}};
      ma_r       <= ZERO;
      mb_r       <= ZERO;
      neg_r      <= 1'b0;
      acc_r      <= ZERO_W;
      busy       <= 1'b0;
      done       <= 1'b0;
      reg_write  <= 1'b0;
      result     <= ZERO;
      result_reg <= {REG_ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done      <= 1'b0;
          reg_write <= 1'b0;
          if (start) begin
            op_r      <= funct3;
            rd_r      <= dest_reg;
            counter_r <= {CW{1'b0}};
            busy      <= 1'b1;
            if (div_zero_s) begin
              // Quotient all ones, remainder is the raw dividend
              acc_r   <= {operand_a, ALL_ONES};
              neg_r   <= 1'b0;
              state_r <= ST_DONE;
            end else if (div_ovf_s) begin
              acc_r   <= {ZERO, INT_MIN};
              neg_r   <= 1'b0;
              state_r <= ST_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!funct3[2]) begin
              acc_r   <= fast_prod_s;
              neg_r   <= 1'b0;
              state_r <= ST_DONE;
            end
`endif
            else begin
              ma_r    <= ma_start_s;
              mb_r    <= mb_start_s;
              neg_r   <= neg_start_s;
              // Divide shifts the dividend out of the low half; multiply the multiplier
              if (funct3[2]) begin
                acc_r <= {ZERO, ma_start_s};
              end else begin
                acc_r <= {ZERO, mb_start_s};
              end
              state_r <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (op_r[2]) begin
            acc_r <= div_next_s;
          end else begin
            acc_r <= mul_next_s;
          end
          counter_r <= counter_r + CW'(1);
          if (counter_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_DONE: begin
          result     <= final_s;
          result_reg <= rd_r;
          done       <= 1'b1;
          reg_write  <= (rd_r != {REG_ADDR_W{1'b0}});
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          reg_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected responses
// from a plain-arithmetic RV32M model; a monitor pops them on every done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_reg;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_reg;
  logic        reg_write;

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .funct3     (funct3),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .dest_reg   (dest_reg),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .result_reg (result_reg),
    .reg_write  (reg_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    int          at;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tmo_cnt = 0;
  bit   req_rst = 1'b0;
  bit   req_busy = 1'b0;
  bit   req_end = 1'b0;
  bit   end_done = 1'b0;

  // RV32M semantics with 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (ovf) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Edges from accept to the edge after which done is visible
  function automatic int lat_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, expv);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv, input bit push, input string nm);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      tmo_cnt++;
      $display("FAIL %s_wait_idle: busy still 1 after %0d cycles, required 0", nm, w);
    end
    funct3 = f; operand_a = a; operand_b = b; dest_reg = rd;
    start = 1'b1; req_busy = 1'b1;
    if (push) begin
      e.res = expv; e.rd = rd; e.rw = (rd != 5'd0);
      e.at = cyc + 1 + lat_model(f, a, b); e.name = nm;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; req_busy = 1'b0;
    // Operands are scrambled after accept; the DUT must not care
    funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom; dest_reg = 5'($urandom);
  endtask

  // Start pulse that must be ignored because the DUT is busy
  task automatic spurious(input int n);
    repeat (n) @(negedge clk);
    start = 1'b1; funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    dest_reg = 5'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      tmo_cnt++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
    end
  endtask

  // Monitor: sampled 1 ns after each rising edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (req_rst) begin
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_result_reg", {27'd0, result_reg}, 32'd0);
      end
      if (req_busy) chk("busy_after_accept", {31'd0, busy}, 32'd1);
      if (!rst) begin
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_result_reg"}, {27'd0, result_reg}, {27'd0, e.rd});
            chk({e.name, "_reg_write"}, {31'd0, reg_write}, {31'd0, e.rw});
            chk({e.name, "_latency_edge"}, 32'(cyc), 32'(e.at));
          end
        end else begin
          chk("reg_write_without_done", {31'd0, reg_write}, 32'd0);
        end
      end
      if (req_end && !end_done) begin
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("wait_timeouts", 32'(tmo_cnt), 32'd0);
        end_done = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [2:0]  f;
    logic [31:0] a, b;
    int          sel, w;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0; dest_reg = 5'd0;
    repeat (2) @(negedge clk);
    req_rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_rst = 1'b0;

    issue(3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b1, "mul_neg");
    issue(3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b1, "mulhu_max");
    issue(3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd7,  32'h00000000, 1'b1, "mulh_m1");
    issue(3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 1'b1, "mulhsu_m1");
    issue(3'b100, 32'hFFFFFFF9,  32'd2,        5'd9,  32'hFFFFFFFD, 1'b1, "div_neg");
    issue(3'b110, 32'hFFFFFFF9,  32'd2,        5'd10, 32'hFFFFFFFF, 1'b1, "rem_neg");
    issue(3'b101, 32'd100,       32'd7,        5'd11, 32'd14,       1'b1, "divu");
    issue(3'b111, 32'd100,       32'd7,        5'd12, 32'd2,        1'b1, "remu");
    issue(3'b100, 32'd5,         32'd0,        5'd13, 32'hFFFFFFFF, 1'b1, "div_by0");
    spurious(0);
    issue(3'b110, 32'd5,         32'd0,        5'd14, 32'd5,        1'b1, "rem_by0");
    issue(3'b100, 32'h80000000,  32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1, "div_ovf");
    issue(3'b110, 32'h80000000,  32'hFFFFFFFF, 5'd16, 32'd0,        1'b1, "rem_ovf");
    issue(3'b101, 32'd1000,      32'd7,        5'd3,  32'd142,      1'b1, "divu_busy_ignore");
    spurious(3);
    issue(3'b101, 32'd50,        32'd5,        5'd0,  32'd10,       1'b1, "divu_rd0");

    // Abort in the middle of CALC; no done may follow
    drain();
    issue(3'b101, 32'd1000, 32'd3, 5'd7, 32'd333, 1'b0, "divu_abort");
    repeat (10) @(negedge clk);
    rst = 1'b1; req_rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'b101, 32'd9, 32'd3, 5'd9, 32'd3, 1'b1, "divu_after_abort");

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom); a = $urandom; b = $urandom; sel = $urandom_range(0, 15);
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h80000000; b = 32'hFFFFFFFF;
      end else if (sel < 5) begin
        a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50));
      end else if (sel == 5) begin
        b = 32'd0 - 32'($urandom_range(1, 9));
      end
      issue(f, a, b, 5'($urandom), ref_model(f, a, b), 1'b1, "rand");
    end

    drain();
    req_end = 1'b1;
    w = 0;
    while (!end_done && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!end_done) begin
      $display("FAIL end_handshake: monitor did not complete final checks");
      $fatal(1, "monitor stalled");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
